// File: rtl/nios2_debug_vjtag_host.sv
// Clk-domain virtual-JTAG initiator for the Nios II debug slave.
// Each accepted command performs one IR load and one DR scan and returns the captured DR.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// UIR   | update-IR strobe, one tck period, ir_out sampled on tck rise
// CDR   | capture-DR strobe, one tck period
// SDR   | shift-DR, DR_LEN tck periods, LSB first on tdi
// UDR   | update-DR strobe, one tck period
// RSP   | response held until rsp_ready
module nios2_debug_vjtag_host #(
  parameter int DR_LEN  = 38,
  parameter int IR_LEN  = 2,
  parameter int TCK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic [IR_LEN-1:0] rsp_ir_out,
  output logic              tck,
  output logic              tdi,
  input  logic              tdo,
  output logic [IR_LEN-1:0] ir_in,
  input  logic [IR_LEN-1:0] ir_out,
  output logic              vs_uir,
  output logic              vs_cdr,
  output logic              vs_sdr,
  output logic              vs_udr,
  output logic              jtag_state_rti
);

  localparam int HW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BW = (DR_LEN > 1) ? $clog2(DR_LEN) : 1;
  localparam logic [HW-1:0] HALF_LOAD = HW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(DR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP
  } state_t;

  state_t            state, state_next;
  logic [HW-1:0]     half_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DR_LEN-1:0] sr;
  logic              scanning;
  logic              half_tc;
  logic              tck_rise;
  logic              period_end;

  assign scanning   = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) || (state == S_UDR);
  assign half_tc    = (half_cnt == '0);
  assign tck_rise   = scanning && half_tc && !tck;
  assign period_end = scanning && half_tc && tck;

  always_comb begin
    state_next     = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready      = 1'b1;
        jtag_state_rti = 1'b1;
        if (cmd_valid) state_next = S_UIR;
      end
      S_UIR: begin
        vs_uir = 1'b1;
        if (period_end) state_next = S_CDR;
      end
      S_CDR: begin
        vs_cdr = 1'b1;
        if (period_end) state_next = S_SDR;
      end
      S_SDR: begin
        vs_sdr = 1'b1;
        if (period_end && (bit_cnt == '0)) state_next = S_UDR;
      end
      S_UDR: begin
        vs_udr = 1'b1;
        if (period_end) state_next = S_RSP;
      end
      S_RSP: begin
        rsp_valid      = 1'b1;
        jtag_state_rti = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      half_cnt   <= HALF_LOAD;
      bit_cnt    <= BIT_LOAD;
      tck        <= 1'b0;
      tdi        <= 1'b0;
      ir_in      <= '0;
      sr         <= '0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      state <= state_next;

      // tck half-period timer: toggles at terminal count, period ends on the falling toggle
      if (!scanning) begin
        half_cnt <= HALF_LOAD;
        tck      <= 1'b0;
      end else if (half_tc) begin
        half_cnt <= HALF_LOAD;
        tck      <= ~tck;
      end else begin
        half_cnt <= half_cnt - HW'(1);
      end

      if (cmd_valid && cmd_ready) begin
        ir_in <= cmd_ir;
        sr    <= cmd_dr;
      end

      if (tck_rise && (state == S_UIR)) rsp_ir_out <= ir_out;
      if (tck_rise && (state == S_SDR)) sr <= {tdo, sr[DR_LEN-1:1]};

      // sr[0] already holds the next outgoing bit by the end of each period
      if (period_end) begin
        case (state)
          S_CDR: begin
            tdi     <= sr[0];
            bit_cnt <= BIT_LOAD;
          end
          S_SDR: begin
            if (bit_cnt == '0) begin
              tdi <= 1'b0;
            end else begin
              tdi     <= sr[0];
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
          S_UDR: rsp_dr <= sr;
          default: ;
        endcase
      end
    end
  end

endmodule
